// File: rtl/avg_feeder_pkg.sv
// avg_feeder_pkg: shared constants and FSM state encoding for the 8-sample averager feeder.
`default_nettype none

package avg_feeder_pkg;

    localparam int N_SAMPLES = 8;
    localparam int DATA_W    = 4;
    localparam int SUM_W     = 7;
    localparam int PTR_W     = 3;

    typedef logic [1:0] state_t;

    localparam state_t FILL   = 2'd0;
    localparam state_t BURST  = 2'd1;
    localparam state_t COMMIT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/avg_sample_feeder_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-cycle rising-edge pulse.
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/avg_sample_feeder.sv
// avg_sample_feeder: buffers eight debounced switch samples, then bursts them as ADD/NUM and commits.
// Define AVG_FEEDER_SUM_EN to add the SUM output (exact sum of the last burst, valid with DONE).
`default_nettype none

module avg_sample_feeder
    import avg_feeder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              BTN_RAW,
    input  logic [DATA_W-1:0] SW,
    output logic              ADD,
    output logic [DATA_W-1:0] NUM,
    output logic [3:0]        COUNT,
    output logic              BUSY,
`ifdef AVG_FEEDER_SUM_EN
    output logic [SUM_W-1:0]  SUM,
`endif
    output logic              DONE
);

    logic              btn_level;
    logic              btn_pulse;
    logic              capture;
    logic              wr_en;

    logic [DATA_W-1:0] sw_s1_q;
    logic [DATA_W-1:0] sw_s2_q;
    logic [DATA_W-1:0] mem_q [N_SAMPLES];

    state_t            state_q,  state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]        count_q,  count_d;
    logic              add_q,    add_d;
    logic [DATA_W-1:0] num_q,    num_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
`ifdef AVG_FEEDER_SUM_EN
    logic [SUM_W-1:0]  acc_q,    acc_d;
    logic [SUM_W-1:0]  sum_q,    sum_d;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .raw_i   (BTN_RAW),
        .level_o (btn_level),
        .pulse_o (btn_pulse)
    );

    assign capture = btn_pulse & btn_level;
    assign wr_en   = capture && (state_q == FILL);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        add_d    = add_q;
        num_d    = num_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef AVG_FEEDER_SUM_EN
        acc_d    = acc_q;
        sum_d    = sum_q;
`endif
        case (state_q)
            FILL: begin
                add_d  = 1'b0;
                num_d  = '0;
                busy_d = 1'b0;
`ifdef AVG_FEEDER_SUM_EN
                acc_d  = '0;
`endif
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + 4'd1;
                    // The 8th write launches the burst with buf[0] already on NUM.
                    if (count_q == 4'(N_SAMPLES - 1)) begin
                        state_d  = BURST;
                        add_d    = 1'b1;
                        busy_d   = 1'b1;
                        num_d    = mem_q[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            BURST: begin
`ifdef AVG_FEEDER_SUM_EN
                acc_d = acc_q + SUM_W'(num_q);
`endif
                // rd_ptr wraps to 0 once all eight samples have been presented.
                if (rd_ptr_q == '0) begin
                    state_d  = COMMIT;
                    add_d    = 1'b0;
                    num_d    = '0;
                    done_d   = 1'b1;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
`ifdef AVG_FEEDER_SUM_EN
                    sum_d    = acc_q + SUM_W'(num_q);
`endif
                end else begin
                    num_d    = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
            COMMIT: begin
                state_d = FILL;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            add_q    <= 1'b0;
            num_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef AVG_FEEDER_SUM_EN
            acc_q    <= '0;
            sum_q    <= '0;
`endif
        end else begin
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            add_q    <= add_d;
            num_q    <= num_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef AVG_FEEDER_SUM_EN
            acc_q    <= acc_d;
            sum_q    <= sum_d;
`endif
        end
    end

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sw_s2_q;
        end
    end

    assign ADD   = add_q;
    assign NUM   = num_q;
    assign COUNT = count_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
`ifdef AVG_FEEDER_SUM_EN
    assign SUM   = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_avg_sample_feeder.sv
// tb_avg_sample_feeder: randomized presses checked against a queue-based model of the feeder.
`default_nettype none

module tb_avg_sample_feeder;
    import avg_feeder_pkg::*;

    localparam int DEB = 3;

    logic              CLK     = 1'b0;
    logic              RST_N   = 1'b0;
    logic              BTN_RAW = 1'b0;
    logic [DATA_W-1:0] SW      = '0;
    logic              ADD;
    logic [DATA_W-1:0] NUM;
    logic [3:0]        COUNT;
    logic              BUSY;
    logic              DONE;
`ifdef AVG_FEEDER_SUM_EN
    logic [SUM_W-1:0]  SUM;
`endif

    avg_sample_feeder #(
        .DEBOUNCE_CYCLES (DEB)
    ) u_dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .BTN_RAW (BTN_RAW),
        .SW      (SW),
        .ADD     (ADD),
        .NUM     (NUM),
        .COUNT   (COUNT),
        .BUSY    (BUSY),
`ifdef AVG_FEEDER_SUM_EN
        .SUM     (SUM),
`endif
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model: accepted samples, expected burst contents and sums.
    int pend_q[$];
    int burst_exp[$];
    int sum_exp[$];
    int drop_end = 0;

    // A press rising after edge r is captured in the cycle after edge r+2+DEB;
    // after the 8th capture, the next 8 BURST cycles and the COMMIT cycle drop captures.
    function automatic void model_capture(input int v, input int r);
        int cap;
        int s;
        cap = r + 2 + DEB;
        s   = 0;
        if (cap <= drop_end) return;
        pend_q.push_back(v);
        if (pend_q.size() == N_SAMPLES) begin
            foreach (pend_q[i]) begin
                burst_exp.push_back(pend_q[i]);
                s += pend_q[i];
            end
            sum_exp.push_back(s);
            pend_q.delete();
            drop_end = cap + N_SAMPLES + 1;
        end
    endfunction

    function automatic void model_reset();
        pend_q.delete();
        burst_exp.delete();
        sum_exp.delete();
        drop_end = 0;
    endfunction

    task automatic press(input int v, input int pre, input int hold, input int gap, input bit glitch);
        SW = 4'(v);
        repeat (pre) @(negedge CLK);
        if (glitch) begin
            repeat (2) begin
                BTN_RAW = 1'b1;
                repeat (2) @(negedge CLK);
                BTN_RAW = 1'b0;
                repeat (2) @(negedge CLK);
            end
        end
        BTN_RAW = 1'b1;
        model_capture(v, cyc);
        repeat (hold) @(negedge CLK);
        BTN_RAW = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic press_chk(input string tag, input int v);
        press(v, 3, 8, 10, 1'b0);
        chk(tag, COUNT, pend_q.size());
    endtask

    // Burst monitor: collects NUM while ADD is high and checks the burst at DONE.
    int burst_q[$];
    bit prev_add = 1'b0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            burst_q.delete();
            prev_add = 1'b0;
        end else begin
            if (ADD) burst_q.push_back(int'(NUM));
            if (DONE) begin
                chk("done_len", burst_q.size(), N_SAMPLES);
                chk("done_add", ADD, 0);
                chk("done_num", NUM, 0);
                chk("done_busy", BUSY, 1);
                chk("done_count", COUNT, 0);
                chk("done_prev_add", prev_add, 1);
                chk("burst_expected", (burst_exp.size() >= N_SAMPLES) ? 1 : 0, 1);
                if (burst_exp.size() >= N_SAMPLES) begin
                    for (int i = 0; i < N_SAMPLES; i++) begin
                        chk($sformatf("burst_num[%0d]", i),
                            (i < burst_q.size()) ? burst_q[i] : -1, burst_exp.pop_front());
                    end
                end
                if (sum_exp.size() > 0) begin
`ifdef AVG_FEEDER_SUM_EN
                    chk("sum", SUM, sum_exp.pop_front());
`else
                    void'(sum_exp.pop_front());
`endif
                end
                burst_q.delete();
            end
            prev_add = ADD;
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_add", ADD, 0);
        chk("rst_num", NUM, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
`ifdef AVG_FEEDER_SUM_EN
        chk("rst_sum", SUM, 0);
`endif
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Samples 1..8, COUNT steps up, then burst 1..8 (sum 36).
        for (int v = 1; v <= N_SAMPLES; v++) press_chk("t1_count", v);

        // Bouncy press gives a single capture.
        press($urandom_range(0, 15), 3, 8, 10, 1'b1);
        chk("t2_glitch_count", COUNT, pend_q.size());

        // Long hold gives one capture; release and re-press gives another.
        press($urandom_range(0, 15), 3, 100, 10, 1'b0);
        chk("t6_long_hold_count", COUNT, pend_q.size());
        press_chk("t6_repress_count", $urandom_range(0, 15));
        for (int i = 0; i < 5; i++) press_chk("t6_fill_count", $urandom_range(0, 15));

        // All-max samples: sum 120.
        for (int i = 0; i < N_SAMPLES; i++) press_chk("t3_count", 15);

        // Press landing while the burst is still busy is dropped.
        for (int i = 0; i < N_SAMPLES - 1; i++) press_chk("t4_count", $urandom_range(0, 8));
        press($urandom_range(0, 8), 3, 5, 0, 1'b0);
        press(9, 4, 8, 10, 1'b0);
        chk("t4_drop_count", COUNT, pend_q.size());
        for (int i = 0; i < N_SAMPLES; i++) press_chk("t4_refill_count", $urandom_range(0, 8));

        // Asynchronous reset in the 4th burst cycle.
        for (int i = 0; i < N_SAMPLES - 1; i++) press_chk("t5_count", $urandom_range(0, 15));
        press($urandom_range(1, 15), 3, 5, 0, 1'b0);
        repeat (4) @(posedge CLK);
        #2;
        chk("t5_add_before_rst", ADD, 1);
        #1 RST_N = 1'b0;
        #1;
        chk("t5_rst_add", ADD, 0);
        chk("t5_rst_num", NUM, 0);
        chk("t5_rst_busy", BUSY, 0);
        chk("t5_rst_count", COUNT, 0);
        chk("t5_rst_done", DONE, 0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < N_SAMPLES; i++) press_chk("t5_refill_count", $urandom_range(0, 15));

        repeat (5) @(negedge CLK);
        chk("all_bursts_seen", burst_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
